// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: widths, ALU op codes, ALUOp classes, funct codes,
// and the ID/EX pipeline payload.
package mips_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned ALUOP_W = 2;

  // ALU operation codes
  localparam logic [OP_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [OP_W-1:0] ALU_OR   = 4'b0001;
  localparam logic [OP_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [OP_W-1:0] ALU_BGTZ = 4'b0100;
  localparam logic [OP_W-1:0] ALU_SUB  = 4'b0110;
  localparam logic [OP_W-1:0] ALU_SLT  = 4'b0111;
  localparam logic [OP_W-1:0] ALU_NOP  = 4'b1111;

  // ALUOp classes from the main decoder
  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [ALUOP_W-1:0] ALUOP_BGTZ  = 2'b11;

  // R-type funct codes
  localparam logic [FUNCT_W-1:0] FUNCT_SLL = 6'b000000;
  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic              memtoreg;
    logic              branch;
    logic              alusrc;
    logic [OP_W-1:0]   alu_op;
    logic [REG_W-1:0]  dest;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
  } id_ex_t;

  // Empty slot: no control, register 0 everywhere so nothing forwards into it
  function automatic id_ex_t bubble();
    id_ex_t b;
    b        = '0;
    b.alu_op = ALU_NOP;
    return b;
  endfunction

endpackage

// File: rtl/alu_ctrl.sv
// ALUOp/funct to ALU operation code decoder (purely combinational).
module alu_ctrl
  import mips_pkg::*;
(
  input  logic [ALUOP_W-1:0] aluop,
  input  logic [FUNCT_W-1:0] funct,
  output logic [OP_W-1:0]    op_c
);

  // Class decode; R-type falls through to the funct table
  always_comb begin
    op_c = ALU_NOP;
    case (aluop)
      ALUOP_ADD:  op_c = ALU_ADD;
      ALUOP_SUB:  op_c = ALU_SUB;
      ALUOP_BGTZ: op_c = ALU_BGTZ;
      default: begin
        case (funct)
          FUNCT_ADD: op_c = ALU_ADD;
          FUNCT_SUB: op_c = ALU_SUB;
          FUNCT_AND: op_c = ALU_AND;
          FUNCT_OR:  op_c = ALU_OR;
          FUNCT_SLT: op_c = ALU_SLT;
          FUNCT_SLL: op_c = ALU_NOP;
          default:   op_c = ALU_NOP;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: operand/control register, forwarding, load-use detection.
module id_ex_stage
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_alusrc,
  input  logic              id_regdst,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_memtoreg,
  input  logic              id_branch,
  input  logic              id_uses_rt,
  input  logic [ALUOP_W-1:0] id_aluop,
  input  logic [FUNCT_W-1:0] id_funct,
  input  logic              stall,
  input  logic              flush,
  input  logic              exmem_regwrite,
  input  logic [REG_W-1:0]  exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_regwrite,
  input  logic [REG_W-1:0]  memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_W-1:0]  ex_dest,
  output logic              ex_valid,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_memtoreg,
  output logic              ex_branch,
  output logic              load_use_hazard
);

  id_ex_t           pipe_q, pipe_d, cap;
  logic [OP_W-1:0]  id_op_c;
  logic [DATA_W-1:0] fwd_rs, fwd_rt;

  alu_ctrl u_alu_ctrl (
    .aluop (id_aluop),
    .funct (id_funct),
    .op_c  (id_op_c)
  );

  // Load in EX whose destination is a source of the instruction in ID
  always_comb begin
    load_use_hazard = 1'b0;
    if (!flush && id_valid && pipe_q.valid && pipe_q.memread && pipe_q.dest != '0 &&
        (pipe_q.dest == id_rs || (id_uses_rt && pipe_q.dest == id_rt)))
      load_use_hazard = 1'b1;
  end

  // Capture payload assembled from decode; invalid slots become bubbles
  always_comb begin
    cap = bubble();
    if (id_valid) begin
      cap.valid    = 1'b1;
      cap.regwrite = id_regwrite;
      cap.memread  = id_memread;
      cap.memwrite = id_memwrite;
      cap.memtoreg = id_memtoreg;
      cap.branch   = id_branch;
      cap.alusrc   = id_alusrc;
      cap.alu_op   = id_op_c;
      cap.dest     = id_regdst ? id_rd : id_rt;
      cap.rs       = id_rs;
      cap.rt       = id_rt;
      cap.rs_data  = id_rs_data;
      cap.rt_data  = id_rt_data;
      cap.imm      = id_imm;
    end
  end

  // Next-state priority: flush, stall hold, load-use bubble, capture
  always_comb begin
    pipe_d = pipe_q;
    if (flush)                pipe_d = bubble();
    else if (stall)           pipe_d = pipe_q;
    else if (load_use_hazard) pipe_d = bubble();
    else                      pipe_d = cap;
  end

  // Pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe_q <= bubble();
    else        pipe_q <= pipe_d;
  end

  // rs forwarding: EX/MEM beats MEM/WB, register 0 never forwarded
  always_comb begin
    fwd_rs = pipe_q.rs_data;
    if (exmem_regwrite && exmem_rd != '0 && exmem_rd == pipe_q.rs)      fwd_rs = exmem_result;
    else if (memwb_regwrite && memwb_rd != '0 && memwb_rd == pipe_q.rs) fwd_rs = memwb_result;
  end

  // rt forwarding, same rules as rs
  always_comb begin
    fwd_rt = pipe_q.rt_data;
    if (exmem_regwrite && exmem_rd != '0 && exmem_rd == pipe_q.rt)      fwd_rt = exmem_result;
    else if (memwb_regwrite && memwb_rd != '0 && memwb_rd == pipe_q.rt) fwd_rt = memwb_result;
  end

  assign alu_a         = fwd_rs;
  assign alu_b         = pipe_q.alusrc ? pipe_q.imm : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign alu_op        = pipe_q.alu_op;
  assign ex_dest       = pipe_q.dest;
  assign ex_valid      = pipe_q.valid;
  assign ex_regwrite   = pipe_q.regwrite;
  assign ex_memread    = pipe_q.memread;
  assign ex_memwrite   = pipe_q.memwrite;
  assign ex_memtoreg   = pipe_q.memtoreg;
  assign ex_branch     = pipe_q.branch;

endmodule
